// File: rtl/float_disc_pkg.sv
// rtl/float_disc_pkg.sv - shared types and widths for the discriminant feeder
package float_disc_pkg;

  localparam int FLEN      = 64;
  // Tags are carried at this width internally and cut to TAG_W at the top ports.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [FLEN-1:0]      a;
    logic [FLEN-1:0]      b;
    logic [FLEN-1:0]      c;
    logic [TAG_MAX_W-1:0] tag;
  } disc_req_t;

  typedef struct packed {
    logic [FLEN-1:0]      res;
    logic                 neg;
    logic                 err;
    logic                 timeout;
    logic [TAG_MAX_W-1:0] tag;
  } disc_rsp_t;

endpackage

// File: rtl/disc_req_fifo.sv
// rtl/disc_req_fifo.sv - synchronous FIFO of disc_req_t, no bypass
module disc_req_fifo
  import float_disc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  disc_req_t push_data,
  input  logic      pop,
  output disc_req_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  disc_req_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/float_discriminant_feeder.sv
// rtl/float_discriminant_feeder.sv - queues (a,b,c,tag) triples, issues them one at a time, holds results
module float_discriminant_feeder
  import float_disc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  in_a,
  input  logic [FLEN-1:0]  in_b,
  input  logic [FLEN-1:0]  in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             disc_arg_vld,
  output logic [FLEN-1:0]  disc_a,
  output logic [FLEN-1:0]  disc_b,
  output logic [FLEN-1:0]  disc_c,
  input  logic             disc_res_vld,
  input  logic [FLEN-1:0]  disc_res,
  input  logic             disc_res_neg,
  input  logic             disc_err,
  input  logic             disc_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_res,
  output logic             out_negative,
  output logic             out_err,
  output logic             out_timeout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [WW-1:0]        wdog;
  logic [TAG_MAX_W-1:0] cur_tag;
  disc_rsp_t            rsp;
  disc_req_t            push_req;
  disc_req_t            head;
  logic                 full;
  logic                 empty;
  logic                 issue;

  assign push_req = '{a: in_a, b: in_b, c: in_c, tag: TAG_MAX_W'(in_tag)};
  assign in_ready = ~full;
  assign issue    = (state == IDLE) && !empty && !disc_busy;

  disc_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_req),
    .pop       (issue),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wdog         <= '0;
      cur_tag      <= '0;
      disc_arg_vld <= 1'b0;
      disc_a       <= '0;
      disc_b       <= '0;
      disc_c       <= '0;
      rsp          <= '0;
      out_valid    <= 1'b0;
    end else begin
      disc_arg_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            disc_a       <= head.a;
            disc_b       <= head.b;
            disc_c       <= head.c;
            cur_tag      <= head.tag;
            disc_arg_vld <= 1'b1;
            wdog         <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // A real result beats the watchdog when both land in the same cycle.
          if (disc_res_vld) begin
            rsp       <= '{res: disc_res, neg: disc_res_neg, err: disc_err,
                           timeout: 1'b0, tag: cur_tag};
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            rsp       <= '{res: '0, neg: 1'b0, err: 1'b1, timeout: 1'b1, tag: cur_tag};
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_res      = rsp.res;
  assign out_negative = rsp.neg;
  assign out_err      = rsp.err;
  assign out_timeout  = rsp.timeout;
  assign out_tag      = TAG_W'(rsp.tag);

endmodule

// File: tb/tb_float_discriminant_feeder.sv
// tb/tb_float_discriminant_feeder.sv - directed bench with a real-arithmetic discriminant stub and result scoreboard
module tb_float_discriminant_feeder;
  import float_disc_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F5  = 64'h4014_0000_0000_0000;
  localparam logic [63:0] F6  = 64'h4018_0000_0000_0000;
  localparam logic [63:0] INF = 64'h7FF0_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid, in_ready;
  logic [FLEN-1:0]  in_a, in_b, in_c;
  logic [TAG_W-1:0] in_tag;
  logic             disc_arg_vld;
  logic [FLEN-1:0]  disc_a, disc_b, disc_c;
  logic             disc_res_vld, disc_res_neg, disc_err, disc_busy;
  logic [FLEN-1:0]  disc_res;
  logic             out_valid, out_ready;
  logic [FLEN-1:0]  out_res;
  logic             out_negative, out_err, out_timeout;
  logic [TAG_W-1:0] out_tag;

  float_discriminant_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
    .disc_arg_vld(disc_arg_vld), .disc_a(disc_a), .disc_b(disc_b), .disc_c(disc_c),
    .disc_res_vld(disc_res_vld), .disc_res(disc_res), .disc_res_neg(disc_res_neg),
    .disc_err(disc_err), .disc_busy(disc_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_negative(out_negative), .out_err(out_err),
    .out_timeout(out_timeout), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      res;
    logic             neg;
    logic             err;
    logic             timeout;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } trip_t;

  exp_t             exp_q[$];
  trip_t            iss_q[$];
  logic [TAG_W-1:0] tags_seen[$];

  int checks = 0;
  int failures = 0;

  logic             stub_dead  = 1'b0;
  int               stub_lat   = 3;
  logic             late_pulse = 1'b0;

  logic [63:0]      last_res;
  logic             last_neg, last_err, last_to;
  logic [TAG_W-1:0] last_tag;
  int               cyc = 0;
  int               arg_cyc = 0;
  int               rise_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // b*b - 4*a*c in real arithmetic; any Inf/NaN operand is reported as an error.
  function automatic void disc_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, output logic [63:0] res,
                                     output logic neg, output logic err);
    real r;
    err = (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF) || (c[62:52] == 11'h7FF);
    if (err) begin
      res = '0;
      neg = 1'b0;
    end else begin
      r   = $bitstoreal(b) * $bitstoreal(b) - 4.0 * $bitstoreal(a) * $bitstoreal(c);
      res = $realtobits(r);
      neg = (r < 0.0);
    end
  endfunction

  // Discriminant unit stand-in; drives on the falling edge.
  initial begin : stub
    logic        pend;
    int          cnt;
    logic [63:0] sa, sb, sc, r;
    logic        n, e;
    pend = 1'b0; cnt = 0; sa = '0; sb = '0; sc = '0;
    disc_res_vld = 1'b0; disc_busy = 1'b0; disc_res = '0; disc_res_neg = 1'b0; disc_err = 1'b0;
    forever begin
      @(negedge clk);
      disc_res_vld = 1'b0;
      if (rst) begin
        pend = 1'b0;
        disc_busy = 1'b0;
      end else if (disc_arg_vld) begin
        pend = !stub_dead;
        cnt  = stub_lat;
        sa = disc_a; sb = disc_b; sc = disc_c;
        disc_busy = !stub_dead;
      end else if (pend) begin
        if (cnt <= 1) begin
          disc_model(sa, sb, sc, r, n, e);
          disc_res = r; disc_res_neg = n; disc_err = e;
          disc_res_vld = 1'b1;
          pend = 1'b0;
          disc_busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (late_pulse) begin
        disc_res_vld = 1'b1;
        disc_res     = 64'h4059_0000_0000_0000;
        disc_res_neg = 1'b1;
        disc_err     = 1'b0;
        late_pulse   = 1'b0;
      end
    end
  end

  // Scoreboard: issued operands and held results against the model queues.
  initial begin : compare
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_ov = 1'b0;
        continue;
      end
      if (disc_arg_vld) begin
        arg_cyc = cyc;
        if (iss_q.size() == 0) begin
          chk("stray_issue", 64'(disc_arg_vld), 64'd0);
        end else begin
          chk("issue_a", disc_a, iss_q[0].a);
          chk("issue_b", disc_b, iss_q[0].b);
          chk("issue_c", disc_c, iss_q[0].c);
          void'(iss_q.pop_front());
        end
      end
      if (out_valid) begin
        if (!prev_ov) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("stray_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("out_res", out_res, exp_q[0].res);
          chk("out_negative", 64'(out_negative), 64'(exp_q[0].neg));
          chk("out_err", 64'(out_err), 64'(exp_q[0].err));
          chk("out_timeout", 64'(out_timeout), 64'(exp_q[0].timeout));
          chk("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
          if (out_ready) begin
            last_res = out_res; last_neg = out_negative; last_err = out_err;
            last_to = out_timeout; last_tag = out_tag;
            tags_seen.push_back(out_tag);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic push_triple(input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [TAG_W-1:0] tag);
    exp_t  e;
    trip_t t;
    bit    ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_c = c; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        t.a = a; t.b = b; t.c = c;
        iss_q.push_back(t);
        if (stub_dead) begin
          e.res = '0; e.neg = 1'b0; e.err = 1'b1; e.timeout = 1'b1;
        end else begin
          disc_model(a, b, c, e.res, e.neg, e.err);
          e.timeout = 1'b0;
        end
        e.tag = tag;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("push_accepted", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: actual=hung required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_arg_vld", 64'(disc_arg_vld), 64'd0);
    chk("rst_disc_a", disc_a, 64'd0);
    chk("rst_out_res", out_res, 64'd0);
    chk("rst_out_flags", {61'd0, out_negative, out_err, out_timeout}, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 25 - 24 = 1.0
    push_triple(F1, F5, F6, 4'd3);
    wait_done();
    chk("t1_res", last_res, 64'h3FF0_0000_0000_0000);
    chk("t1_neg", 64'(last_neg), 64'd0);
    chk("t1_err", 64'(last_err), 64'd0);
    chk("t1_tag", 64'(last_tag), 64'd3);

    // 2: 4 - 20 = -16
    push_triple(F1, F2, F5, 4'd9);
    wait_done();
    chk("t2_res", last_res, 64'hC030_0000_0000_0000);
    chk("t2_neg", 64'(last_neg), 64'd1);

    // 3: infinite operand
    push_triple(INF, F1, F1, 4'd5);
    wait_done();
    chk("t3_err", 64'(last_err), 64'd1);
    chk("t3_timeout", 64'(last_to), 64'd0);

    // 4: fill with the consumer stalled, then drain in order
    out_ready = 1'b0;
    tags_seen.delete();
    for (int i = 0; i < DEPTH + 1; i++)
      push_triple(F1, $realtobits(real'(i + 3)), F1, TAG_W'(i));
    chk("t4_full", 64'(in_ready), 64'd0);
    fork
      push_triple(F1, $realtobits(real'(DEPTH + 4)), F1, TAG_W'(DEPTH + 1));
    join_none
    repeat (3) @(negedge clk);
    chk("t4_still_full", 64'(in_ready), 64'd0);
    chk("t4_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    wait_done();
    chk("t4_count", 64'(tags_seen.size()), 64'(DEPTH + 2));
    for (int i = 0; i < tags_seen.size(); i++)
      chk("t4_order", 64'(tags_seen[i]), 64'(i));

    // 5: lost result, then stray late pulses
    stub_dead = 1'b1;
    out_ready = 1'b0;
    push_triple(F1, F5, F6, 4'd7);
    for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_latency", 64'(rise_cyc - arg_cyc), 64'(TIMEOUT));
    chk("t5_err", 64'(out_err), 64'd1);
    chk("t5_timeout", 64'(out_timeout), 64'd1);
    chk("t5_res", out_res, 64'd0);
    late_pulse = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_late_res", out_res, 64'd0);
    chk("t5_late_timeout", 64'(out_timeout), 64'd1);
    stub_dead = 1'b0;
    out_ready = 1'b1;
    wait_done();
    chk("t5_tag", 64'(last_tag), 64'd7);
    late_pulse = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_idle_pulse", 64'(out_valid), 64'd0);

    // 6: reset while waiting with entries queued
    stub_lat = 50;
    for (int i = 0; i < 4; i++) push_triple(F1, F5, F6, TAG_W'(i));
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(negedge clk);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_arg_vld", 64'(disc_arg_vld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stub_lat = 3;
    repeat (3) @(negedge clk);
    push_triple(F1, F2, F5, 4'hA);
    wait_done();
    chk("t6_res", last_res, 64'hC030_0000_0000_0000);
    chk("t6_tag", 64'(last_tag), 64'hA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
